// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - register-file write-port controller: init sweep, then round-robin writeback arbitration.
// Optional contention counter enabled by defining REG_WB_ARB_CONTENTION_EN.
module reg_wb_arbiter #(
  parameter int                NUM_REGS   = 32,
  parameter int                ADDR_W     = 5,
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              init_done
`ifdef REG_WB_ARB_CONTENTION_EN
  , output logic [15:0]     contention_count
`endif
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] init_cnt;
  logic              rr_ptr;
  logic              acc0;
  logic              acc1;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // rr_ptr names the last granted requester; on a tie the other one wins.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state == ST_RUN) begin
      req0_ready = req0_valid && (!req1_valid || rr_ptr);
      req1_ready = req1_valid && (!req0_valid || !rr_ptr);
    end
  end

  assign acc0     = req0_valid && req0_ready;
  assign acc1     = req1_valid && req1_ready;
  assign sel_addr = acc1 ? req1_addr : req0_addr;
  assign sel_data = acc1 ? req1_data : req0_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      rr_ptr    <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      init_done <= 1'b0;
    end else if (state == ST_INIT) begin
      wr_en    <= 1'b1;
      wr_addr  <= init_cnt;
      wr_data  <= INIT_VALUE;
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == ADDR_W'(NUM_REGS - 1)) begin
        state     <= ST_RUN;
        init_done <= 1'b1;
      end
    end else begin
      // Writes to x0 still complete the handshake but never reach the file.
      wr_en <= (acc0 || acc1) && (sel_addr != '0);
      if ((acc0 || acc1) && (sel_addr != '0)) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end
      if (acc0) begin
        rr_ptr <= 1'b0;
      end else if (acc1) begin
        rr_ptr <= 1'b1;
      end
    end
  end

`ifdef REG_WB_ARB_CONTENTION_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contention_count <= '0;
    end else if (state == ST_RUN && req0_valid && req1_valid &&
                 contention_count != 16'hFFFF) begin
      contention_count <= contention_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - directed table-driven bench for reg_wb_arbiter.
module tb_reg_wb_arbiter;

  logic        clock;
  logic        reset;
  logic        req0_valid;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        init_done;
`ifdef REG_WB_ARB_CONTENTION_EN
  logic [15:0] contention_count;
`endif

  int checks;
  int failures;

  reg_wb_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .init_done  (init_done)
`ifdef REG_WB_ARB_CONTENTION_EN
    , .contention_count (contention_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        r0;
    logic        r1;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Caller leaves reset released just after a clock edge.
  task automatic init_sweep();
    for (int k = 0; k < 32; k++) begin
      check($sformatf("init_ready0_%0d", k), {31'd0, req0_ready}, 32'd0);
      check($sformatf("init_ready1_%0d", k), {31'd0, req1_ready}, 32'd0);
      check($sformatf("init_done_pre_%0d", k), {31'd0, init_done}, 32'd0);
      step();
      check($sformatf("init_wen_%0d", k), {31'd0, wr_en}, 32'd1);
      check($sformatf("init_waddr_%0d", k), {27'd0, wr_addr}, 32'(k));
      check($sformatf("init_wdata_%0d", k), wr_data, 32'h0);
    end
    check("init_done_after", {31'd0, init_done}, 32'd1);
  endtask

  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    //            v0  a0     d0            v1  a1     d1        r0 r1 wen waddr  wdata
    tbl[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    0, 0, 0, 5'd31, 32'h0};
    tbl[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,    1, 0, 1, 5'd5,  32'hDEADBEEF};
    tbl[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    0, 0, 0, 5'd5,  32'hDEADBEEF};
    tbl[3]  = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd4,  32'h44,   0, 1, 1, 5'd4,  32'h44};
    tbl[4]  = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd4,  32'h44,   1, 0, 1, 5'd3,  32'h33};
    tbl[5]  = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd4,  32'h44,   0, 1, 1, 5'd4,  32'h44};
    tbl[6]  = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd4,  32'h44,   1, 0, 1, 5'd3,  32'h33};
    tbl[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h1234, 0, 1, 0, 5'd3,  32'h33};
    tbl[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h77,   0, 1, 1, 5'd7,  32'h77};
    tbl[9]  = '{1'b1, 5'd9,  32'h99,       1'b1, 5'd10, 32'hAA,   1, 0, 1, 5'd9,  32'h99};
    tbl[10] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,    1, 0, 1, 5'd31, 32'hFFFFFFFF};
    tbl[11] = '{1'b1, 5'd0,  32'h5,        1'b1, 5'd2,  32'h22,   0, 1, 1, 5'd2,  32'h22};
    tbl[12] = '{1'b1, 5'd0,  32'h5,        1'b1, 5'd2,  32'h22,   1, 0, 0, 5'd2,  32'h22};
    tbl[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    0, 0, 0, 5'd2,  32'h22};

    // Reset with both requesters pending; they must be held off through init.
    reset = 1'b1;
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    step();
    step();
    check("rst_wen", {31'd0, wr_en}, 32'd0);
    check("rst_waddr", {27'd0, wr_addr}, 32'd0);
    check("rst_wdata", wr_data, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_ready0", {31'd0, req0_ready}, 32'd0);
    check("rst_ready1", {31'd0, req1_ready}, 32'd0);
    reset = 1'b0;
    init_sweep();

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1);
      #1;
      check($sformatf("v%0d_ready0", i), {31'd0, req0_ready}, {31'd0, tbl[i].r0});
      check($sformatf("v%0d_ready1", i), {31'd0, req1_ready}, {31'd0, tbl[i].r1});
      step();
      check($sformatf("v%0d_wen", i), {31'd0, wr_en}, {31'd0, tbl[i].wen});
      check($sformatf("v%0d_waddr", i), {27'd0, wr_addr}, {27'd0, tbl[i].waddr});
      check($sformatf("v%0d_wdata", i), wr_data, tbl[i].wdata);
    end

    // Reset while a registered write is on the port.
    drive(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'h0);
    step();
    check("mid_wen_before", {31'd0, wr_en}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_wen_async", {31'd0, wr_en}, 32'd0);
    check("mid_init_done", {31'd0, init_done}, 32'd0);
    check("mid_ready0", {31'd0, req0_ready}, 32'd0);
    step();
    reset = 1'b0;
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    init_sweep();

    // Pointer restarts at 0, so a tie goes to req1 first.
    #1;
    check("post_rst_ready1", {31'd0, req1_ready}, 32'd1);
    check("post_rst_ready0", {31'd0, req0_ready}, 32'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

`ifdef REG_WB_ARB_CONTENTION_EN
    check("cont_after_init", {16'd0, contention_count}, 32'd0);
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    for (int i = 0; i < 10; i++) step();
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 5; i++) step();
    check("cont_count", {16'd0, contention_count}, 32'd10);
    reset = 1'b1;
    #1;
    check("cont_reset", {16'd0, contention_count}, 32'd0);
    step();
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
